// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared monitor definitions: ASCII constants, parser state, command encoding
// and the registered strobe bundle of the UART command controller.
package uart_cmd_ctrl_pkg;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_SP  = 8'h20;
  localparam logic [7:0] ASCII_ESC = 8'h1B;

  localparam logic [7:0] CH_W = 8'h77;
  localparam logic [7:0] CH_I = 8'h69;
  localparam logic [7:0] CH_R = 8'h72;
  localparam logic [7:0] CH_P = 8'h70;
  localparam logic [7:0] CH_G = 8'h67;
  localparam logic [7:0] CH_Z = 8'h7A;
  localparam logic [7:0] CH_S = 8'h73;
  localparam logic [7:0] CH_Q = 8'h71;

  typedef enum logic [1:0] {S_IDLE, S_ARG, S_SKIP} parse_state_e;

  typedef enum logic [2:0] {CMD_W, CMD_I, CMD_R, CMD_P, CMD_G, CMD_Z, CMD_S, CMD_Q} cmd_e;

  typedef enum logic {DUMP_R, DUMP_P} dump_e;

  typedef struct packed {
    logic valid;
    cmd_e cmd;
  } cmd_dec_t;

  typedef struct packed {
    logic write_address_set;
    logic write_data_en;
    logic inst_address_set;
    logic inst_data_en;
    logic read_start_set;
    logic read_end_set;
    logic read_stop;
    logic pgm_start_set;
    logic pgm_end_set;
    logic pgm_stop;
    logic start_trush;
    logic start_step;
    logic cpu_start;
    logic quit_cmd;
    logic cmd_error;
  } strobes_t;

  function automatic logic [7:0] to_lower(input logic [7:0] b);
    return (b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
  endfunction

  function automatic cmd_dec_t decode_cmd(input logic [7:0] b);
    cmd_dec_t r;
    r.valid = 1'b1;
    r.cmd   = CMD_W;
    case (to_lower(b))
      CH_W:    r.cmd = CMD_W;
      CH_I:    r.cmd = CMD_I;
      CH_R:    r.cmd = CMD_R;
      CH_P:    r.cmd = CMD_P;
      CH_G:    r.cmd = CMD_G;
      CH_Z:    r.cmd = CMD_Z;
      CH_S:    r.cmd = CMD_S;
      CH_Q:    r.cmd = CMD_Q;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Byte input, busy status and strobe/operand outputs of the command controller.
// master = the controller, slave = the UART RX / uart_logics side.
interface uart_cmd_ctrl_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        dump_running;
  logic        trush_running;
  logic [31:0] uart_data;
  logic        write_address_set, write_data_en, inst_address_set, inst_data_en;
  logic        read_start_set, read_end_set, read_stop;
  logic        pgm_start_set, pgm_end_set, pgm_stop;
  logic        start_trush, start_step, cpu_start, quit_cmd;
  logic        cmd_error;

  modport master (
    input  rx_data, rx_valid, dump_running, trush_running,
    output uart_data,
    output write_address_set, write_data_en, inst_address_set, inst_data_en,
    output read_start_set, read_end_set, read_stop,
    output pgm_start_set, pgm_end_set, pgm_stop,
    output start_trush, start_step, cpu_start, quit_cmd, cmd_error
  );

  modport slave (
    output rx_data, rx_valid, dump_running, trush_running,
    input  uart_data,
    input  write_address_set, write_data_en, inst_address_set, inst_data_en,
    input  read_start_set, read_end_set, read_stop,
    input  pgm_start_set, pgm_end_set, pgm_stop,
    input  start_trush, start_step, cpu_start, quit_cmd, cmd_error
  );
endinterface

// File: rtl/uart_cmd_ctrl_hex_nibble_dec.sv
// Combinational ASCII hex digit decoder: 0-9, a-f, A-F to a 4-bit nibble.
module hex_nibble_dec (
  input  logic [7:0] byte_in,
  output logic       is_hex,
  output logic [3:0] nibble
);
  always_comb begin
    is_hex = 1'b0;
    nibble = 4'd0;
    if (byte_in >= 8'h30 && byte_in <= 8'h39) begin
      is_hex = 1'b1;
      nibble = byte_in[3:0];
    end else if ((byte_in >= 8'h41 && byte_in <= 8'h46) ||
                 (byte_in >= 8'h61 && byte_in <= 8'h66)) begin
      // low nibble of 'A'/'a' is 1, so +9 maps it to 10
      is_hex = 1'b1;
      nibble = byte_in[3:0] + 4'd9;
    end
  end
endmodule

// File: rtl/uart_cmd_ctrl.sv
// ASCII command line parser: turns typed monitor commands into one-cycle
// control strobes plus a 32-bit operand, and honours stop requests while busy.
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter bit ACCEPT_LF = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_cmd_ctrl_if.master bus
);

  parse_state_e state_q, state_d;
  cmd_e         cmd_q, cmd_d;
  logic [31:0]  uart_data_q, uart_data_d;
  logic [1:0]   field_idx_q, field_idx_d;
  logic         have_digit_q, have_digit_d;
  dump_e        last_dump_q, last_dump_d;
  strobes_t     stb_q, stb_d;

  logic         is_hex;
  logic [3:0]   nibble;
  logic         is_term, is_space, is_stop, busy, close_err;
  logic [2:0]   n_fields;
  cmd_dec_t     dec;

  hex_nibble_dec u_hex (
    .byte_in (bus.rx_data),
    .is_hex  (is_hex),
    .nibble  (nibble)
  );

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    uart_data_d  = uart_data_q;
    field_idx_d  = field_idx_q;
    have_digit_d = have_digit_q;
    last_dump_d  = last_dump_q;
    stb_d        = '0;
    close_err    = 1'b0;
    dec          = decode_cmd(bus.rx_data);
    is_term      = (bus.rx_data == ASCII_CR) || (ACCEPT_LF && (bus.rx_data == ASCII_LF));
    is_space     = (bus.rx_data == ASCII_SP);
    is_stop      = (to_lower(bus.rx_data) == CH_Q) || (bus.rx_data == ASCII_ESC);
    busy         = bus.dump_running | bus.trush_running;
    // fields on the line including the one a separator is about to close
    n_fields     = {1'b0, field_idx_q} + {2'b00, have_digit_q};

    if (bus.rx_valid) begin
      if (busy) begin
        if (is_stop) begin
          if (bus.dump_running) begin
            if (last_dump_q == DUMP_P) stb_d.pgm_stop  = 1'b1;
            else                       stb_d.read_stop = 1'b1;
          end
          state_d = S_IDLE;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (dec.valid) begin
              cmd_d        = dec.cmd;
              field_idx_d  = 2'd0;
              have_digit_d = 1'b0;
              state_d      = S_ARG;
            end else if (!is_term && !is_space) begin
              stb_d.cmd_error = 1'b1;
              state_d         = S_SKIP;
            end
          end

          S_ARG: begin
            if (is_hex) begin
              uart_data_d  = have_digit_q ? {uart_data_q[27:0], nibble} : {28'd0, nibble};
              have_digit_d = 1'b1;
            end else if (is_space || is_term) begin
              if (have_digit_q) begin
                have_digit_d = 1'b0;
                field_idx_d  = (field_idx_q == 2'd2) ? 2'd2 : field_idx_q + 2'd1;
                case (cmd_q)
                  CMD_W: begin
                    if (field_idx_q == 2'd0) stb_d.write_address_set = 1'b1;
                    else                     stb_d.write_data_en     = 1'b1;
                  end
                  CMD_I: begin
                    if (field_idx_q == 2'd0) stb_d.inst_address_set = 1'b1;
                    else                     stb_d.inst_data_en     = 1'b1;
                  end
                  CMD_R: begin
                    if (field_idx_q == 2'd0) begin
                      stb_d.read_start_set = 1'b1;
                      last_dump_d          = DUMP_R;
                    end else if (field_idx_q == 2'd1) begin
                      stb_d.read_end_set = 1'b1;
                    end else begin
                      close_err = 1'b1;
                    end
                  end
                  CMD_P: begin
                    if (field_idx_q == 2'd0) begin
                      stb_d.pgm_start_set = 1'b1;
                      last_dump_d         = DUMP_P;
                    end else if (field_idx_q == 2'd1) begin
                      stb_d.pgm_end_set = 1'b1;
                    end else begin
                      close_err = 1'b1;
                    end
                  end
                  CMD_G:   close_err = (field_idx_q != 2'd0);
                  default: ;
                endcase
              end

              if (close_err) begin
                stb_d.cmd_error = 1'b1;
                state_d         = is_term ? S_IDLE : S_SKIP;
              end else if (is_term) begin
                state_d = S_IDLE;
                case (cmd_q)
                  CMD_G: begin
                    if (n_fields == 3'd1) stb_d.cpu_start = 1'b1;
                    else                  stb_d.cmd_error = 1'b1;
                  end
                  CMD_Z: begin
                    if (n_fields == 3'd0) stb_d.start_trush = 1'b1;
                    else                  stb_d.cmd_error   = 1'b1;
                  end
                  CMD_S: begin
                    if (n_fields == 3'd0) stb_d.start_step = 1'b1;
                    else                  stb_d.cmd_error  = 1'b1;
                  end
                  CMD_Q: begin
                    if (n_fields == 3'd0) stb_d.quit_cmd  = 1'b1;
                    else                  stb_d.cmd_error = 1'b1;
                  end
                  default: ;
                endcase
              end
            end else begin
              stb_d.cmd_error = 1'b1;
              state_d         = S_SKIP;
            end
          end

          S_SKIP: begin
            if (is_term) state_d = S_IDLE;
          end

          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cmd_q        <= CMD_W;
      uart_data_q  <= 32'd0;
      field_idx_q  <= 2'd0;
      have_digit_q <= 1'b0;
      last_dump_q  <= DUMP_R;
      stb_q        <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      uart_data_q  <= uart_data_d;
      field_idx_q  <= field_idx_d;
      have_digit_q <= have_digit_d;
      last_dump_q  <= last_dump_d;
      stb_q        <= stb_d;
    end
  end

  assign bus.uart_data         = uart_data_q;
  assign bus.write_address_set = stb_q.write_address_set;
  assign bus.write_data_en     = stb_q.write_data_en;
  assign bus.inst_address_set  = stb_q.inst_address_set;
  assign bus.inst_data_en      = stb_q.inst_data_en;
  assign bus.read_start_set    = stb_q.read_start_set;
  assign bus.read_end_set      = stb_q.read_end_set;
  assign bus.read_stop         = stb_q.read_stop;
  assign bus.pgm_start_set     = stb_q.pgm_start_set;
  assign bus.pgm_end_set       = stb_q.pgm_end_set;
  assign bus.pgm_stop          = stb_q.pgm_stop;
  assign bus.start_trush       = stb_q.start_trush;
  assign bus.start_step        = stb_q.start_step;
  assign bus.cpu_start         = stb_q.cpu_start;
  assign bus.quit_cmd          = stb_q.quit_cmd;
  assign bus.cmd_error         = stb_q.cmd_error;

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

ASCII command parser/sequencer for the UART monitor: consumes received bytes from the UART RX block and issues the one-cycle control pulses and the 32-bit `uart_data` operand that drive the monitor memory-write, dump, trash and CPU-control logic. It sits between the UART receiver and `uart_logics`. It turns typed command lines into the exact strobe sequence that block expects, and it blocks new commands while a dump or trash is running.

## Interface
- `ACCEPT_LF`, 1: LF (0x0A) terminates a line like CR (0x0D); when 0, LF is an error character.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `rx_data` in 8: received byte; valid only while `rx_valid`.
- `rx_valid` in 1: one-cycle strobe per byte; no backpressure.
- `dump_running` in 1: dump sequencer busy.
- `trush_running` in 1: memory trash busy.
- `uart_data` out 32: operand accumulator.
- `write_address_set`, `write_data_en`, `inst_address_set`, `inst_data_en` out 1 each: dmem/imem write strobes.
- `read_start_set`, `read_end_set`, `read_stop` out 1 each: data-dump strobes.
- `pgm_start_set`, `pgm_end_set`, `pgm_stop` out 1 each: imem-dump strobes.
- `start_trush`, `start_step`, `cpu_start`, `quit_cmd` out 1 each: control pulses.
- `cmd_error` out 1: one-cycle pulse on a parse error.

## Operation
- Line grammar: command letter, then hex fields separated by one or more spaces, then a terminator (CR, or LF when enabled).
  - Command letters are case-insensitive.
  - Hex digits are 0-9, a-f, A-F.
- States are S_IDLE, S_ARG and S_SKIP.
  - S_IDLE: a command letter latches `cmd` and moves to S_ARG. A terminator is ignored (empty line). A space is ignored. Any other byte pulses `cmd_error` and moves to S_SKIP.
  - S_ARG: a hex digit does `uart_data <= {uart_data[27:0], nibble}`. The first digit of a field loads `{28'd0, nibble}`. More than 8 digits keeps the last 8.
  - A field closes on a space or terminator that follows at least one digit. On close, `field_idx` increments and saturates at 2.
  - S_SKIP: discard bytes until a terminator, then go to S_IDLE.
- Pulses on field close, indexed by `field_idx` before the increment:
  - `w`: 0 → `write_address_set`; ≥1 → `write_data_en`, once per data field.
  - `i`: 0 → `inst_address_set`; ≥1 → `inst_data_en`.
  - `r`: 0 → `read_start_set`; 1 → `read_end_set`; 2 → `cmd_error` and S_SKIP.
  - `p`: same as `r`, using `pgm_start_set` / `pgm_end_set`.
  - `g`: 0 → no pulse; ≥1 → `cmd_error` and S_SKIP.
- Pulses on terminator, in S_ARG:
  - `g` with exactly 1 field → `cpu_start`. `uart_data` then holds the start address.
  - `z` → `start_trush`.
  - `s` → `start_step`.
  - `q` → `quit_cmd`.
  - `z`/`s`/`q` with any field → `cmd_error`, with no command pulse.
  - `g` with 0 fields → `cmd_error`.
  - Every terminator returns the parser to S_IDLE.
- A non-hex, non-space, non-terminator byte in S_ARG → `cmd_error` and S_SKIP.
- Busy rule: while `dump_running | trush_running`:
  - Every byte is discarded except `q`/`Q` and ESC (0x1B).
  - A `q`/`Q`/ESC byte pulses `read_stop` if the last dump was `r`, or `pgm_stop` if it was `p`. No stop pulse is issued while only trashing.
  - After the stop, the parser is forced to S_IDLE.
  - `quit_cmd` is never issued while busy.
- `last_dump` register: set to R on `read_start_set` and to P on `pgm_start_set`. Reset value is R.

## Timing
- All outputs are registered.
- Pulses are asserted exactly one cycle, in the cycle after the `rx_valid` of the closing byte.
- `uart_data` is updated in the cycle after a digit's `rx_valid`. It is stable during, and after, every strobe that consumes it; it is not altered by separators.
- At most one command strobe (plus `cmd_error`) per byte. Back-to-back `rx_valid` every cycle must be handled.
- The busy check uses the inputs sampled in the same cycle as `rx_valid`.
- Reset: state S_IDLE, `uart_data` = 0, `field_idx` = 0, `last_dump` = R, all strobes 0.
- Asserting `rst_n` mid-line abandons the line with no pulses.

## Structure
- Shared monitor package holds:
  - ASCII constants: CR, LF, SP, ESC and the command letters.
  - The parser-state enum.
  - The `cmd` encoding.
- One natural sub-module, `hex_nibble_dec`: byte in → `{is_hex, nibble}`, combinational.
- Everything else lives in the top module.

## Test plan
- "w 100 DEADBEEF 1 CR" → `write_address_set` with `uart_data`=0x100, then `write_data_en` with 0xDEADBEEF, then `write_data_en` with 0x1.
- "r 0 3f CR" → `read_start_set` with 0x0 and `read_end_set` with 0x3F. Then, with `dump_running`=1, "x" is ignored and "q" gives a single `read_stop` with no `quit_cmd`.
- "p 10 20 30 CR" → `pgm_start_set`, `pgm_end_set`, then `cmd_error` on the third field. The line is discarded and the next "s CR" gives `start_step`.
- "g 123456789 CR" → `cpu_start` with `uart_data`=0x23456789. "z CR" while `trush_running`=1 → no pulse.
- "k CR" → `cmd_error` only. "w 1G CR" → `write_address_set` never fires. Reset asserted mid "w 12" → no strobes, `uart_data`=0.
